// File: rtl/game_pkg.sv
// game_pkg: shared state, screen and colour types for the sprite controllers
package game_pkg;
  localparam int SCREEN_H = 720;
  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;
endpackage

// File: rtl/vsync_tick.sv
// vsync_tick: one-cycle frame tick on the rising edge of v_sync, suppressed on the first cycle after reset
module vsync_tick (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_v_sync,
  output logic o_tick
);
  logic v_sync_q, armed;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      v_sync_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      v_sync_q <= i_v_sync;
      armed    <= 1'b1;
    end
  // armed masks a v_sync that was already high while reset was held
  assign o_tick = armed & i_v_sync & ~v_sync_q;
endmodule

// File: rtl/finish_label_ctrl.sv
// finish_label_ctrl: slides the FINISH label in per frame, blinks it, holds it, and composites it over the background
module finish_label_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LABEL_X       = 466,
  parameter int unsigned TARGET_Y      = 296,
  parameter int unsigned START_Y       = SCREEN_H,
  parameter int unsigned STEP_Y        = 8,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_finish,
  input  logic        i_restart,
  input  logic        i_label_hit,
  input  logic [7:0]  i_label_red,
  input  logic [7:0]  i_label_green,
  input  logic [7:0]  i_label_blue,
  input  logic [7:0]  i_bg_red,
  input  logic [7:0]  i_bg_green,
  input  logic [7:0]  i_bg_blue,
  output logic [15:0] o_label_x,
  output logic [15:0] o_label_y,
  output logic        o_label_visible,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_busy,
  output logic        o_done
);
  state_t      state, state_nx;
  logic [15:0] y, y_nx, frame_cnt, frame_nx;
  logic [7:0]  tog, tog_nx;
  logic        vis, vis_nx, tick, landed, blink_wrap;
  logic [16:0] y_sub;
  rgb_t        rgb_q, label_rgb, bg_rgb;

  vsync_tick u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_v_sync (i_v_sync),
    .o_tick   (tick)
  );

  // 17-bit subtract so an oversize step reads as underflow and clamps
  assign y_sub      = {1'b0, y} - 17'(STEP_Y);
  assign landed     = y_sub[16] || y_sub <= 17'(TARGET_Y);
  assign blink_wrap = frame_cnt == 16'(BLINK_FRAMES - 1);

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state     <= IDLE;
      y         <= 16'(START_Y);
      vis       <= 1'b0;
      frame_cnt <= '0;
      tog       <= '0;
    end else begin
      state     <= state_nx;
      y         <= y_nx;
      vis       <= vis_nx;
      frame_cnt <= frame_nx;
      tog       <= tog_nx;
    end

  always_comb begin
    state_nx = state;
    y_nx     = y;
    vis_nx   = vis;
    frame_nx = frame_cnt;
    tog_nx   = tog;
    if (i_restart && state != IDLE) begin
      state_nx = IDLE;
      y_nx     = 16'(START_Y);
      vis_nx   = 1'b0;
      frame_nx = '0;
      tog_nx   = '0;
    end else begin
      case (state)
        IDLE: if (i_finish) begin
          state_nx = SLIDE;
          vis_nx   = 1'b1;
        end
        SLIDE: if (tick) begin
          y_nx = landed ? 16'(TARGET_Y) : y_sub[15:0];
          if (landed) begin
            state_nx = BLINK;
            frame_nx = '0;
            tog_nx   = '0;
          end
        end
        BLINK: if (tick) begin
          frame_nx = blink_wrap ? 16'd0 : frame_cnt + 16'd1;
          if (blink_wrap) begin
            vis_nx = ~vis;
            tog_nx = tog + 8'd1;
            if (tog_nx == 8'(BLINK_TOGGLES)) begin
              state_nx = HOLD;
              vis_nx   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy = state != IDLE;
    o_done = state == HOLD;
  end

  assign label_rgb = {i_label_red, i_label_green, i_label_blue};
  assign bg_rgb    = {i_bg_red, i_bg_green, i_bg_blue};

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) rgb_q <= '0;
    else       rgb_q <= (vis && i_label_hit) ? label_rgb : bg_rgb;

  assign o_label_x       = 16'(LABEL_X);
  assign o_label_y       = y;
  assign o_label_visible = vis;
  assign o_red           = rgb_q.red;
  assign o_green         = rgb_q.green;
  assign o_blue          = rgb_q.blue;
endmodule
